// File: rtl/fme_ctrl_pkg.sv
// Shared FSM encoding and default depth for the FME best-candidate buffer and its controller.
// The buffer instantiation uses DEPTH_DEF too, so the two depths cannot diverge.
package fme_ctrl_pkg;

   localparam int DEPTH_DEF = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DRAIN  = 2'd2
   } state_t;

endpackage

// File: rtl/valid_shadow_chain.sv
// Valid/last shadow of the candidate buffer plus occupancy counter; state moves one stage per i_shift.
// Holds on no shift; i_clear empties everything and takes priority over i_shift, i_inc and i_dec.
module valid_shadow_chain
   import fme_ctrl_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int OCC_W = 4
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_clear,
   input  logic             i_shift,
   input  logic             i_in_vld,
   input  logic             i_in_lst,
   input  logic             i_inc,
   input  logic             i_dec,
   output logic [DEPTH-1:0] o_vld,
   output logic [DEPTH-1:0] o_lst,
   output logic [OCC_W-1:0] o_occ
);

   logic [DEPTH-1:0] r_vld;
   logic [DEPTH-1:0] r_lst;
   logic [OCC_W-1:0] r_occ;

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_vld <= '0;
         r_lst <= '0;
         r_occ <= '0;
      end else if (i_clear) begin
         r_vld <= '0;
         r_lst <= '0;
         r_occ <= '0;
      end else begin
         if (i_shift) begin
            r_vld <= {r_vld[DEPTH-2:0], i_in_vld};
            r_lst <= {r_lst[DEPTH-2:0], i_in_lst};
         end
         // Count tracks entries in and out, so no popcount over r_vld is needed.
         if (i_inc && !i_dec)
            r_occ <= r_occ + OCC_W'(1);
         else if (i_dec && !i_inc)
            r_occ <= r_occ - OCC_W'(1);
      end
   end

   assign o_vld = r_vld;
   assign o_lst = r_lst;
   assign o_occ = r_occ;

endmodule

// File: rtl/candidate_buffer_ctrl.sv
// Enable/valid sequencer for the FME candidate delay buffer: a set appears at the output DEPTH shifts after acceptance.
// A held output (out_valid & ~out_ready) freezes every stage and drops in_ready; DRAIN blocks input until empty.
module candidate_buffer_ctrl
   import fme_ctrl_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int OCC_W = 4,
   parameter int CNT_W = 16
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_abort,
   input  logic             i_in_valid,
   input  logic             i_in_last,
   output logic             o_in_ready,
   input  logic             i_out_ready,
   output logic             o_out_valid,
   output logic             o_out_last,
   output logic             o_buf_enable,
   output logic [OCC_W-1:0] o_occupancy,
   output logic [CNT_W-1:0] o_sets_count,
   output logic             o_done
);

   state_t           r_state;
   logic             r_run;
   logic             r_done;
   logic [CNT_W-1:0] r_cnt;

   logic [DEPTH-1:0] w_vld;
   logic [DEPTH-1:0] w_lst;
   logic             w_adv;
   logic             w_in_ready;
   logic             w_in_fire;
   logic             w_out_fire;
   logic             w_shift;

   assign w_adv      = r_run & (~w_vld[DEPTH-1] | i_out_ready);
   assign w_in_ready = w_adv & (r_state != DRAIN);
   assign w_in_fire  = i_in_valid & w_in_ready;
   assign w_out_fire = w_vld[DEPTH-1] & i_out_ready & w_adv;
   assign w_shift    = w_adv & (w_in_fire | w_out_fire | ((r_state == DRAIN) & (|w_vld)));

   valid_shadow_chain #(
      .DEPTH (DEPTH),
      .OCC_W (OCC_W)
   ) u_chain (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_clear  (i_abort),
      .i_shift  (w_shift),
      .i_in_vld (w_in_fire),
      .i_in_lst (w_in_fire & i_in_last),
      .i_inc    (w_in_fire),
      .i_dec    (w_out_fire),
      .o_vld    (w_vld),
      .o_lst    (w_lst),
      .o_occ    (o_occupancy)
   );

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= IDLE;
         r_run   <= 1'b0;
         r_done  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_run <= 1'b1;
         if (i_abort) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
         end else begin
            r_done <= w_out_fire & w_lst[DEPTH-1];
            if (w_out_fire)
               r_cnt <= r_cnt + CNT_W'(1);
            case (r_state)
               IDLE, ACTIVE: begin
                  if (w_in_fire)
                     r_state <= i_in_last ? DRAIN : ACTIVE;
               end
               DRAIN: begin
                  // Input is blocked here, so an empty chain means the last set has left.
                  if (w_vld == '0)
                     r_state <= IDLE;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign o_in_ready   = w_in_ready;
   assign o_out_valid  = w_vld[DEPTH-1];
   assign o_out_last   = w_lst[DEPTH-1] & w_vld[DEPTH-1];
   assign o_buf_enable = w_shift & ~i_abort;
   assign o_sets_count = r_cnt;
   assign o_done       = r_done;

endmodule

// File: tb/tb_candidate_buffer_ctrl.sv
// Bench for candidate_buffer_ctrl: directed scenarios plus random traffic against a queue-based reference.
module tb_candidate_buffer_ctrl;

   localparam int DEPTH = 8;
   localparam int OCC_W = 4;
   localparam int CNT_W = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic abort = 1'b0;
   logic in_valid = 1'b0;
   logic in_last = 1'b0;
   logic out_ready = 1'b0;

   logic             in_ready, out_valid, out_last, buf_en, done;
   logic [OCC_W-1:0] occ;
   logic [CNT_W-1:0] cnt;
   logic             in_ready4, out_valid4, out_last4, buf_en4, done4;
   logic [OCC_W-1:0] occ4;
   logic [3:0]       cnt4;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   candidate_buffer_ctrl #(.DEPTH(DEPTH), .OCC_W(OCC_W), .CNT_W(CNT_W)) u_dut (
      .i_clock(clk), .i_reset(rst_n), .i_abort(abort), .i_in_valid(in_valid), .i_in_last(in_last),
      .o_in_ready(in_ready), .i_out_ready(out_ready), .o_out_valid(out_valid), .o_out_last(out_last),
      .o_buf_enable(buf_en), .o_occupancy(occ), .o_sets_count(cnt), .o_done(done));

   candidate_buffer_ctrl #(.DEPTH(DEPTH), .OCC_W(OCC_W), .CNT_W(4)) u_dut4 (
      .i_clock(clk), .i_reset(rst_n), .i_abort(abort), .i_in_valid(in_valid), .i_in_last(in_last),
      .o_in_ready(in_ready4), .i_out_ready(out_ready), .o_out_valid(out_valid4), .o_out_last(out_last4),
      .o_buf_enable(buf_en4), .o_occupancy(occ4), .o_sets_count(cnt4), .o_done(done4));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: each set in flight is a queue entry holding the number of shifts it has seen.
   int q_pos[$];
   bit q_last[$];
   bit m_run;
   int m_mode;   // 0 idle, 1 mid-macroblock, 2 draining
   bit m_done;
   int m_cnt;

   function automatic void model_reset();
      q_pos.delete();
      q_last.delete();
      m_run  = 1'b0;
      m_mode = 0;
      m_done = 1'b0;
      m_cnt  = 0;
   endfunction

   function automatic bit m_ovld();
      return m_run && q_pos.size() > 0 && q_pos[0] == DEPTH - 1;
   endfunction
   function automatic bit m_olast();
      return m_ovld() && q_last[0];
   endfunction
   function automatic bit m_adv();
      return m_run && (!m_ovld() || out_ready);
   endfunction
   function automatic bit m_inr();
      return m_adv() && m_mode != 2;
   endfunction
   function automatic bit m_inf();
      return in_valid && m_inr();
   endfunction
   function automatic bit m_outf();
      return m_ovld() && out_ready && m_adv();
   endfunction
   function automatic bit m_shift();
      return m_adv() && (m_inf() || m_outf() || (m_mode == 2 && q_pos.size() > 0));
   endfunction

   always @(posedge clk) begin : mdl
      bit ol, inf, outf, sh, emp;
      if (rst_n) begin
         ol   = m_olast();
         inf  = m_inf();
         outf = m_outf();
         sh   = m_shift();
         emp  = (q_pos.size() == 0);
         if (abort) begin
            q_pos.delete();
            q_last.delete();
            m_mode = 0;
            m_done = 1'b0;
         end else begin
            m_done = outf && ol;
            if (outf) begin
               void'(q_pos.pop_front());
               void'(q_last.pop_front());
               m_cnt++;
            end
            if (sh)
               for (int i = 0; i < q_pos.size(); i++) q_pos[i] = q_pos[i] + 1;
            if (inf) begin
               q_pos.push_back(0);
               q_last.push_back(in_last);
               m_mode = in_last ? 2 : 1;
            end else if (m_mode == 2 && emp) begin
               m_mode = 0;
            end
         end
         m_run = 1'b1;
      end
   end

   always @(negedge clk) begin
      check("out_valid", out_valid, m_ovld());
      check("out_last", out_last, m_olast());
      check("in_ready", in_ready, m_inr());
      check("buf_enable", buf_en, m_shift() && !abort);
      check("occupancy", occ, q_pos.size());
      check("sets_count", cnt, m_cnt % 65536);
      check("done", done, m_done);
      check("w4_out_valid", out_valid4, m_ovld());
      check("w4_out_last", out_last4, m_olast());
      check("w4_in_ready", in_ready4, m_inr());
      check("w4_buf_enable", buf_en4, m_shift() && !abort);
      check("w4_occupancy", occ4, q_pos.size());
      check("w4_done", done4, m_done);
      check("w4_sets_count", cnt4, m_cnt % 16);
   end

   // Per-cycle observations and phase statistics gathered by tick().
   bit s_acc, s_ov, s_fire, s_en, s_done, s_inr;
   int s_occ, s_cnt;
   int acc, fires, last_idx, dones, ens, maxocc, cyc, first_acc, first_ov;

   task automatic clr_stats();
      acc = 0; fires = 0; last_idx = 0; dones = 0; ens = 0; maxocc = 0;
      cyc = 0; first_acc = -1; first_ov = -1;
   endtask

   task automatic tick(input bit v, input bit l, input bit r, input bit a);
      in_valid = v; in_last = l; out_ready = r; abort = a;
      @(negedge clk);
      s_acc  = in_valid && in_ready && !abort;
      s_ov   = out_valid;
      s_fire = out_valid && out_ready && !abort;
      s_en   = buf_en;
      s_done = done;
      s_inr  = in_ready;
      s_occ  = int'(occ);
      s_cnt  = int'(cnt);
      if (s_acc) begin
         if (first_acc < 0) first_acc = cyc;
         acc++;
      end
      if (s_ov && first_ov < 0) first_ov = cyc;
      if (s_fire) begin
         fires++;
         if (out_last) last_idx = fires;
      end
      if (s_done) dones++;
      if (s_en) ens++;
      if (s_occ > maxocc) maxocc = s_occ;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input int n, input int gap, input int budget);
      for (int c = 0; c < budget; c++) begin
         bit v;
         v = (acc < n) && (c % gap == 0);
         tick(v, v && (acc == n - 1), 1'b1, 1'b0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      clr_stats();
      #2;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_buf_enable", buf_en, 0);
      check("rst_occupancy", occ, 0);
      check("rst_sets_count", cnt, 0);
      check("rst_done", done, 0);
      #20 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Streaming: 20 back-to-back sets, last on #20.
      clr_stats();
      feed(20, 1, 60);
      check("stream_latency", first_ov - first_acc, 8);
      check("stream_fires", fires, 20);
      check("stream_last_idx", last_idx, 20);
      check("stream_dones", dones, 1);
      check("stream_count", cnt, 20);
      check("stream_occ_end", occ, 0);
      check("stream_idle_ready", in_ready, 1);

      // Backpressure: fill the buffer, stall 5 cycles, then release.
      clr_stats();
      for (int c = 0; c < 20 && acc < 8; c++) tick(1'b1, 1'b0, 1'b0, 1'b0);
      check("bp_fill", acc, 8);
      for (int c = 0; c < 5; c++) begin
         tick(1'b1, 1'b0, 1'b0, 1'b0);
         check("bp_enable", s_en, 0);
         check("bp_in_ready", s_inr, 0);
         check("bp_occ", s_occ, 8);
      end
      for (int c = 0; c < 40; c++) begin
         bit v;
         v = (acc < 12);
         tick(v, v && acc == 11, 1'b1, 1'b0);
      end
      check("bp_fires", fires, 12);
      check("bp_last_idx", last_idx, 12);
      check("bp_dones", dones, 1);

      // Sparse input: one set every third cycle.
      clr_stats();
      feed(10, 3, 80);
      check("sparse_fires", fires, 10);
      check("sparse_occ_bound", maxocc <= DEPTH, 1);
      check("sparse_dones", dones, 1);

      // Drain with in_valid held high behind the last set.
      clr_stats();
      for (int c = 0; c < 10 && acc < 4; c++) tick(1'b1, acc == 3, 1'b1, 1'b0);
      check("drain_acc", acc, 4);
      ens = 0;
      for (int c = 0; c < 30 && dones == 0; c++) begin
         tick(1'b1, 1'b1, 1'b1, 1'b0);
         check("drain_in_ready", s_inr, 0);
      end
      check("drain_shifts", ens, 8);
      check("drain_dones", dones, 1);
      check("drain_fires", fires, 4);
      begin
         bit seen;
         seen = 1'b0;
         for (int c = 0; c < 5 && !seen; c++) begin
            tick(1'b1, 1'b1, 1'b1, 1'b0);
            if (s_inr) seen = 1'b1;
         end
         check("drain_ready_back", seen, 1);
      end
      for (int c = 0; c < 20; c++) tick(1'b0, 1'b0, 1'b1, 1'b0);
      check("drain_total_count", cnt, 47);

      // Abort with five sets in flight.
      clr_stats();
      for (int c = 0; c < 20 && acc < 5; c++) tick(1'b1, 1'b0, 1'b0, 1'b0);
      check("abort_fill", acc, 5);
      tick(1'b1, 1'b0, 1'b1, 1'b1);
      check("abort_enable", s_en, 0);
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      check("abort_occ", s_occ, 0);
      check("abort_out_valid", s_ov, 0);
      check("abort_done", s_done, 0);
      check("abort_count", s_cnt, 47);
      check("abort_idle_ready", s_inr, 1);

      // Random traffic, then an abort to return to a known state.
      for (int c = 0; c < 600; c++)
         tick(1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0,
              $urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0);
      tick(1'b0, 1'b0, 1'b1, 1'b1);
      tick(1'b0, 1'b0, 1'b1, 1'b0);

      // Asynchronous reset in the middle of a drain.
      clr_stats();
      for (int c = 0; c < 10 && acc < 3; c++) tick(1'b1, acc == 2, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("arst_out_valid", out_valid, 0);
      check("arst_out_last", out_last, 0);
      check("arst_in_ready", in_ready, 0);
      check("arst_buf_enable", buf_en, 0);
      check("arst_occupancy", occ, 0);
      check("arst_sets_count", cnt, 0);
      check("arst_done", done, 0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Counter wrap on the 4-bit instance.
      clr_stats();
      feed(17, 1, 50);
      check("wrap_fires", fires, 17);
      check("wrap_count16", cnt, 17);
      check("wrap_count4", cnt4, 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
